// File: rtl/qpu_trigger_queue.sv
// qpu_trigger_queue
//   Multi-channel timed-event dispatcher. Each channel owns a DEPTH-entry
//   FIFO of (timestamp, payload). A channel's head entry fires once the
//   shared time base has reached its timestamp. A fire is a one-cycle valid
//   pulse with a latched payload, plus a sticky per-channel late flag.
//
// Ports
//   clk, rst_n          single clock, async active-low reset
//   i_valid/i_ready     enqueue handshake (i_ready = ~full[i_ch] & ~i_flush)
//   i_ch/i_time/i_data  target channel, fire timestamp, payload
//   i_flush             synchronous clear of all queues and late flags
//   trigger_i_clk       free-running time base
//   trigger_o_clk_ena   timer run request (any channel non-empty)
//   trigger_o_valid     per-channel fire pulse
//   trigger_o_data      per-channel fired payload, channel c at [c*DATA_W +: DATA_W]
//   o_full/o_empty      per-channel FIFO status
//   o_late              sticky: channel fired strictly after its timestamp
module qpu_trigger_queue #(
  parameter int CH_NUM = 4,
  parameter int DATA_W = 8,
  parameter int TIME_W = 32,
  parameter int DEPTH  = 8,
  parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [CH_W-1:0]          i_ch,
  input  logic [TIME_W-1:0]        i_time,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_flush,
  input  logic [TIME_W-1:0]        trigger_i_clk,
  output logic                     trigger_o_clk_ena,
  output logic [CH_NUM-1:0]        trigger_o_valid,
  output logic [CH_NUM*DATA_W-1:0] trigger_o_data,
  output logic [CH_NUM-1:0]        o_full,
  output logic [CH_NUM-1:0]        o_empty,
  output logic [CH_NUM-1:0]        o_late
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr_q [CH_NUM];
  logic [PW-1:0]     wr_ptr_d [CH_NUM];
  logic [PW-1:0]     rd_ptr_q [CH_NUM];
  logic [PW-1:0]     rd_ptr_d [CH_NUM];
  logic [TIME_W-1:0] mem_time_q [CH_NUM][DEPTH];
  logic [DATA_W-1:0] mem_data_q [CH_NUM][DEPTH];

  logic [CH_NUM-1:0]        valid_q, valid_d;
  logic [CH_NUM-1:0]        late_q, late_d;
  logic [CH_NUM*DATA_W-1:0] data_q, data_d;
  logic                     clk_ena_q, clk_ena_d;

  logic [CH_NUM-1:0] full, empty, push, due;
  logic              sel_full;

  // Status flags come straight from the pointer flops, so they reflect an
  // event one cycle after it happens.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      full[c]  = (wr_ptr_q[c][PW-1] != rd_ptr_q[c][PW-1]) &&
                 (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
    end
  end

  // Out-of-range channels match no entry here, so they are accepted and dropped.
  always_comb begin
    sel_full = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (i_ch == CH_W'(c)) sel_full = full[c];
    end
  end

  assign i_ready = ~sel_full & ~i_flush;

  always_comb begin
    logic [TIME_W-1:0] diff;
    valid_d   = '0;
    late_d    = late_q;
    data_d    = data_q;
    clk_ena_d = 1'b0;
    push      = '0;
    due       = '0;
    diff      = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      // Wrap-aware compare: due once the modular difference is non-negative.
      diff    = trigger_i_clk - mem_time_q[c][rd_ptr_q[c][AW-1:0]];
      due[c]  = ~empty[c] & ~diff[TIME_W-1] & ~i_flush;
      push[c] = i_valid & i_ready & (i_ch == CH_W'(c));

      wr_ptr_d[c] = wr_ptr_q[c] + PW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(due[c]);

      if (due[c]) begin
        valid_d[c]                  = 1'b1;
        data_d[c*DATA_W +: DATA_W]  = mem_data_q[c][rd_ptr_q[c][AW-1:0]];
        if (diff != '0) late_d[c]   = 1'b1;
      end

      if (i_flush) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        late_d[c]   = 1'b0;
      end

      // Run request follows post-update occupancy.
      if (wr_ptr_d[c] != rd_ptr_d[c]) clk_ena_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      valid_q   <= '0;
      late_q    <= '0;
      data_q    <= '0;
      clk_ena_q <= 1'b0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      valid_q   <= valid_d;
      late_q    <= late_d;
      data_q    <= data_d;
      clk_ena_q <= clk_ena_d;
    end
  end

  // Entry storage needs no reset: an entry is only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (push[c]) begin
        mem_time_q[c][wr_ptr_q[c][AW-1:0]] <= i_time;
        mem_data_q[c][wr_ptr_q[c][AW-1:0]] <= i_data;
      end
    end
  end

  assign trigger_o_valid   = valid_q;
  assign trigger_o_data    = data_q;
  assign trigger_o_clk_ena = clk_ena_q;
  assign o_late            = late_q;
  assign o_full            = full;
  assign o_empty           = empty;

endmodule

// File: tb/tb_qpu_trigger_queue.sv
module tb_qpu_trigger_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [1:0]  i_ch = '0;
  logic [31:0] i_time = '0;
  logic [7:0]  i_data = '0;
  logic        i_flush = 1'b0;
  logic [31:0] tclk = '0;
  logic        clk_ena;
  logic [3:0]  o_valid;
  logic [31:0] o_data;
  logic [3:0]  o_full;
  logic [3:0]  o_empty;
  logic [3:0]  o_late;

  int n_checks = 0;
  int n_pass = 0;

  qpu_trigger_queue #(
    .CH_NUM(4), .DATA_W(8), .TIME_W(32), .DEPTH(8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_valid           (i_valid),
    .i_ready           (i_ready),
    .i_ch              (i_ch),
    .i_time            (i_time),
    .i_data            (i_data),
    .i_flush           (i_flush),
    .trigger_i_clk     (tclk),
    .trigger_o_clk_ena (clk_ena),
    .trigger_o_valid   (o_valid),
    .trigger_o_data    (o_data),
    .o_full            (o_full),
    .o_empty           (o_empty),
    .o_late            (o_late)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (o_empty !== 4'hF) $display("FAIL reset_empty: got %b want 1111", o_empty); else n_pass++;
    n_checks++; if (o_full !== 4'h0) $display("FAIL reset_full: got %b want 0000", o_full); else n_pass++;
    n_checks++; if (o_valid !== 4'h0 || o_data !== 32'h0) $display("FAIL reset_out: valid %b data %h want 0/0", o_valid, o_data); else n_pass++;
    n_checks++; if (o_late !== 4'h0 || clk_ena !== 1'b0) $display("FAIL reset_late_ena: late %b ena %b want 0", o_late, clk_ena); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_ordered_fire();
    logic exp_v;
    for (int n = 0; n <= 15; n++) begin
      tclk    = 32'(n);
      i_valid = (n < 3);
      i_ch    = 2'd2;
      i_time  = 32'(10 + n);
      i_data  = 8'(161 + n);
      step();
      i_valid = 1'b0;
      exp_v = (n >= 10 && n <= 12);
      n_checks++; if (o_valid !== {1'b0, exp_v, 2'b00}) $display("FAIL ordered_valid n=%0d: got %b want %b", n, o_valid, {1'b0, exp_v, 2'b00}); else n_pass++;
      if (exp_v) begin
        n_checks++; if (o_data[23:16] !== 8'(161 + n - 10)) $display("FAIL ordered_data n=%0d: got %h want %h", n, o_data[23:16], 8'(161 + n - 10)); else n_pass++;
      end
      n_checks++; if (clk_ena !== (n < 12)) $display("FAIL ordered_clk_ena n=%0d: got %b want %b", n, clk_ena, (n < 12)); else n_pass++;
    end
    n_checks++; if (o_late !== 4'h0) $display("FAIL ordered_late: got %b want 0000", o_late); else n_pass++;
    n_checks++; if (o_empty !== 4'hF) $display("FAIL ordered_empty: got %b want 1111", o_empty); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic [3:0] seen;
    tclk = 32'd0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_ch = 2'd1; i_time = 32'd1000; i_data = 8'(k);
      step();
    end
    i_valid = 1'b0;
    n_checks++; if (o_empty !== 4'b1101 || clk_ena !== 1'b1) $display("FAIL mid_pre: empty %b ena %b want 1101/1", o_empty, clk_ena); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (o_empty !== 4'hF || o_full !== 4'h0) $display("FAIL mid_rst_flags: empty %b full %b want 1111/0000", o_empty, o_full); else n_pass++;
    n_checks++; if (o_data !== 32'h0 || o_valid !== 4'h0) $display("FAIL mid_rst_out: data %h valid %b want 0/0", o_data, o_valid); else n_pass++;
    n_checks++; if (clk_ena !== 1'b0 || o_late !== 4'h0) $display("FAIL mid_rst_ena: ena %b late %b want 0/0000", clk_ena, o_late); else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 100; k++) begin
      tclk = 32'(k);
      step();
      seen |= o_valid;
    end
    n_checks++; if (seen !== 4'h0) $display("FAIL idle_pulses: got %b want 0000", seen); else n_pass++;
    n_checks++; if (o_empty !== 4'hF) $display("FAIL idle_empty: got %b want 1111", o_empty); else n_pass++;
  endtask

  task automatic test_late_wrap();
    tclk = 32'h100;
    i_valid = 1'b1; i_ch = 2'd0; i_time = 32'h50; i_data = 8'h55;
    step();
    i_valid = 1'b0;
    step();
    n_checks++; if (o_valid !== 4'b0001 || o_data[7:0] !== 8'h55) $display("FAIL late_fire: valid %b data %h want 0001/55", o_valid, o_data[7:0]); else n_pass++;
    n_checks++; if (o_late !== 4'b0001) $display("FAIL late_flag: got %b want 0001", o_late); else n_pass++;
    step();
    n_checks++; if (o_valid !== 4'h0) $display("FAIL late_single: got %b want 0000", o_valid); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tclk = 32'hFFFF_FFFE + 32'(k);
      i_valid = (k == 0); i_ch = 2'd0; i_time = 32'h1; i_data = 8'h66;
      step();
      i_valid = 1'b0;
      n_checks++; if (o_valid[0] !== (k == 3)) $display("FAIL wrap_valid k=%0d: got %b want %b", k, o_valid[0], (k == 3)); else n_pass++;
      if (k == 2) begin
        n_checks++; if (o_data[7:0] !== 8'h55) $display("FAIL wrap_hold: got %h want 55", o_data[7:0]); else n_pass++;
      end
      if (k == 3) begin
        n_checks++; if (o_data[7:0] !== 8'h66) $display("FAIL wrap_data: got %h want 66", o_data[7:0]); else n_pass++;
      end
    end
    n_checks++; if (o_late !== 4'b0001) $display("FAIL late_sticky: got %b want 0001", o_late); else n_pass++;
    i_flush = 1'b1;
    #1;
    n_checks++; if (i_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", i_ready); else n_pass++;
    step();
    i_flush = 1'b0;
    n_checks++; if (o_late !== 4'h0) $display("FAIL late_clear: got %b want 0000", o_late); else n_pass++;
  endtask

  task automatic test_full();
    tclk = 32'd0;
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1; i_ch = 2'd3; i_time = 32'd1000; i_data = 8'(k);
      #1;
      n_checks++; if (i_ready !== (k < 8)) $display("FAIL full_ready k=%0d: got %b want %b", k, i_ready, (k < 8)); else n_pass++;
      step();
    end
    i_valid = 1'b0;
    n_checks++; if (o_full !== 4'b1000 || o_empty !== 4'b0111) $display("FAIL full_flags: full %b empty %b want 1000/0111", o_full, o_empty); else n_pass++;
    i_ch = 2'd0;
    #1;
    n_checks++; if (i_ready !== 1'b1) $display("FAIL full_other_ready: got %b want 1", i_ready); else n_pass++;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    n_checks++; if (o_full !== 4'h0 || o_empty !== 4'hF) $display("FAIL full_flush: full %b empty %b want 0000/1111", o_full, o_empty); else n_pass++;
  endtask

  task automatic test_concurrency();
    logic v0, v1;
    logic [7:0] exp_d;
    for (int n = 40; n <= 82; n++) begin
      tclk = 32'(n);
      i_valid = 1'b0;
      case (n)
        40: begin i_valid = 1'b1; i_ch = 2'd0; i_time = 32'd50; i_data = 8'h10; end
        41: begin i_valid = 1'b1; i_ch = 2'd1; i_time = 32'd50; i_data = 8'h20; end
        42: begin i_valid = 1'b1; i_ch = 2'd0; i_time = 32'd60; i_data = 8'h11; end
        43: begin i_valid = 1'b1; i_ch = 2'd0; i_time = 32'd70; i_data = 8'h12; end
        50: begin i_valid = 1'b1; i_ch = 2'd0; i_time = 32'd80; i_data = 8'h13; end
        default: ;
      endcase
      step();
      i_valid = 1'b0;
      v0 = (n == 50 || n == 60 || n == 70 || n == 80);
      v1 = (n == 50);
      n_checks++; if (o_valid !== {2'b00, v1, v0}) $display("FAIL conc_valid n=%0d: got %b want %b", n, o_valid, {2'b00, v1, v0}); else n_pass++;
      if (v0) begin
        exp_d = (n == 50) ? 8'h10 : (n == 60) ? 8'h11 : (n == 70) ? 8'h12 : 8'h13;
        n_checks++; if (o_data[7:0] !== exp_d) $display("FAIL conc_data0 n=%0d: got %h want %h", n, o_data[7:0], exp_d); else n_pass++;
      end
      if (n == 50) begin
        n_checks++; if (o_data[15:8] !== 8'h20) $display("FAIL conc_data1: got %h want 20", o_data[15:8]); else n_pass++;
      end
      if (n == 75) begin
        n_checks++; if (o_empty[0] !== 1'b0) $display("FAIL conc_occupancy: empty0 %b want 0", o_empty[0]); else n_pass++;
      end
    end
    n_checks++; if (o_empty !== 4'hF || o_late !== 4'h0) $display("FAIL conc_end: empty %b late %b want 1111/0000", o_empty, o_late); else n_pass++;
    n_checks++; if (o_data !== 32'h0000_2013) $display("FAIL conc_hold: got %h want 00002013", o_data); else n_pass++;
  endtask

  task automatic test_flush();
    logic [3:0] seen;
    for (int n = 100; n <= 109; n++) begin
      tclk = 32'(n);
      i_valid = 1'b0;
      case (n)
        100: begin i_valid = 1'b1; i_ch = 2'd0; i_time = 32'd110; i_data = 8'hB0; end
        101: begin i_valid = 1'b1; i_ch = 2'd1; i_time = 32'd110; i_data = 8'hB1; end
        102: begin i_valid = 1'b1; i_ch = 2'd2; i_time = 32'd110; i_data = 8'hB2; end
        103: begin i_valid = 1'b1; i_ch = 2'd3; i_time = 32'd110; i_data = 8'hB3; end
        104: begin i_valid = 1'b1; i_ch = 2'd0; i_time = 32'd111; i_data = 8'hB4; end
        default: ;
      endcase
      i_flush = (n == 109);
      if (n == 109) begin
        n_checks++; if (o_empty !== 4'h0 || clk_ena !== 1'b1) $display("FAIL flush_pre: empty %b ena %b want 0000/1", o_empty, clk_ena); else n_pass++;
      end
      step();
      i_valid = 1'b0;
      i_flush = 1'b0;
    end
    n_checks++; if (o_empty !== 4'hF || o_late !== 4'h0 || clk_ena !== 1'b0) $display("FAIL flush_post: empty %b late %b ena %b want 1111/0000/0", o_empty, o_late, clk_ena); else n_pass++;
    n_checks++; if (o_data !== 32'h0000_2013) $display("FAIL flush_data: got %h want 00002013", o_data); else n_pass++;
    seen = o_valid;
    for (int n = 110; n < 130; n++) begin
      tclk = 32'(n);
      step();
      seen |= o_valid;
    end
    n_checks++; if (seen !== 4'h0) $display("FAIL flush_pulses: got %b want 0000", seen); else n_pass++;
    // Flush in the very cycle an entry is due: it must not fire.
    tclk = 32'd200;
    i_valid = 1'b1; i_ch = 2'd2; i_time = 32'd200; i_data = 8'hC2;
    step();
    i_valid = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    n_checks++; if (o_valid !== 4'h0 || o_empty !== 4'hF) $display("FAIL flush_due: valid %b empty %b want 0000/1111", o_valid, o_empty); else n_pass++;
    step();
    n_checks++; if (o_valid !== 4'h0 || o_data !== 32'h0000_2013) $display("FAIL flush_due_after: valid %b data %h want 0000/00002013", o_valid, o_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ordered_fire();
    test_reset_midstream();
    test_late_wrap();
    test_full();
    test_concurrency();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
